// File: rtl/rv_mem_pkg.sv
// Shared memory-subsystem definitions: default widths for the multithreaded
// core's RAM ports and a helper that sizes round-robin pointers.
package rv_mem_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_THREADS = 4;

    // Bits needed to index n requesters; never less than one bit.
    function automatic int ptr_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rv_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr and wrapping at N-1. Shared by the data-port and
// instruction-fetch arbiters.
module rv_rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'((int'(ptr) + off) % N);
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rv_ram_port_arbiter.sv
// Round-robin arbiter for RAM port B shared by the per-thread load/store units.
// One access per cycle, a lock hint for back-to-back ownership, and read data
// routed back to the winner one cycle after acceptance.
//
// Handshake: a request is accepted in the cycle where req_valid[i] & req_ready[i]
// are both high; req_ready is combinational and at most one-hot. Requesters hold
// their req_* fields stable until accepted. Exactly one cycle after acceptance
// rsp_valid[i] pulses for one cycle (reads and writes alike) with rsp_rdata
// carrying the read data for reads and zero for writes.
module rv_ram_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_THREADS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [DATA_WIDTH-1:0]         ram_addr,
    output logic                          ram_we,
    output logic [DATA_WIDTH-1:0]         ram_in,
    input  logic [DATA_WIDTH-1:0]         ram_out
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   lock_owner;
    logic               lock_active;
    logic [NUM_REQ-1:0] rsp_sel;
    logic               rsp_is_read;

    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    logic               lock_hit;
    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;

    rv_rr_picker #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_picker (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // Lock owner overrides rotation while it keeps its request up; nothing is
    // granted during reset so the RAM sees an idle port.
    always_comb begin
        lock_hit   = lock_active && req_valid[lock_owner];
        gnt_valid  = !rst && (lock_hit || pick_valid);
        gnt_idx    = lock_hit ? lock_owner : pick_idx;
        gnt_onehot = '0;
        if (gnt_valid) begin
            if (lock_hit) begin
                gnt_onehot[lock_owner] = 1'b1;
            end else begin
                gnt_onehot = pick_grant;
            end
        end
    end

    assign req_ready = gnt_onehot;

    // Steer the winner's request onto the RAM port; idle port drives zeros.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_in   = '0;
        if (gnt_valid) begin
            ram_we   = req_we[gnt_idx];
            ram_addr = req_addr[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            ram_in   = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Rotation pointer, lock state and response routing, updated per grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            lock_owner  <= '0;
            lock_active <= 1'b0;
            rsp_sel     <= '0;
            rsp_is_read <= 1'b0;
        end else if (gnt_valid) begin
            rr_ptr      <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            lock_owner  <= gnt_idx;
            lock_active <= req_lock[gnt_idx];
            rsp_sel     <= gnt_onehot;
            rsp_is_read <= !req_we[gnt_idx];
        end else begin
            lock_active <= 1'b0;
            rsp_sel     <= '0;
            rsp_is_read <= 1'b0;
        end
    end

    // Response outputs; a response still pending when reset hits is dropped.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!rst) begin
            rsp_valid = rsp_sel;
            if ((|rsp_sel) && rsp_is_read) begin
                rsp_rdata = ram_out;
            end
        end
    end

endmodule

// File: doc/rv_ram_port_arbiter.md
# rv_ram_port_arbiter

Round-robin arbiter sharing the read/write data port (port B) of `rv_multiport_ram` between the per-thread load/store units of the multithreaded core. Grants at most one request per cycle, drives the RAM port directly, and routes read data back to the winning thread one cycle later. Supports a lock hint so a thread can hold the port for back-to-back accesses, such as read-modify-write.

## Interface
- `DATA_WIDTH`, 32: data and address width; matches RAM port B.
- `NUM_REQ`, 4: number of requesters (hardware threads). Must be ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: request present, one bit per requester.
- `req_we`  in  NUM_REQ: 1 = write, 0 = read.
- `req_lock`  in  NUM_REQ: hold the grant on the next cycle if still valid.
- `req_addr`  in  NUM_REQ*DATA_WIDTH: flattened addresses; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH: flattened write data.
- `req_ready`  out  NUM_REQ: one-hot or zero; a request is accepted when valid & ready.
- `rsp_valid`  out  NUM_REQ: one-hot or zero; response for the request accepted in the previous cycle.
- `rsp_rdata`  out  DATA_WIDTH: read data, qualified by `rsp_valid`.
- `ram_addr`  out  DATA_WIDTH: to RAM `port_b_addr`.
- `ram_we`  out  1: to RAM `port_b_we`.
- `ram_in`  out  DATA_WIDTH: to RAM `port_b_in`.
- `ram_out`  in  DATA_WIDTH: from RAM `port_b_out`. Valid one cycle after the address is presented.

## Operation
- State:
  - `rr_ptr` (log2 NUM_REQ bits): highest-priority requester.
  - `lock_owner` + `lock_active`: lock state.
  - `rsp_sel` (one-hot): response routing.
  - `rsp_is_read`: whether the pending response is a read.
- Grant selection (combinational, every cycle):
  - If `lock_active` and `req_valid[lock_owner]`, grant `lock_owner`.
  - Otherwise grant the first set `req_valid` bit searching from `rr_ptr` upward, wrapping NUM_REQ-1 → 0.
  - No valid request: no grant.
- On a grant to requester g:
  - `req_ready[g]`=1.
  - `ram_addr`/`ram_we`/`ram_in` = slice g.
  - `rr_ptr` ← (g+1) mod NUM_REQ at the clock edge.
  - `lock_active` ← `req_lock[g]`; `lock_owner` ← g.
- No grant:
  - `ram_we`=0, `ram_addr`=0, `ram_in`=0.
  - `lock_active` ← 0; `rr_ptr` holds.
- Lock released early if the owner drops `req_valid`. Other requesters wait while a lock is held; no timeout.
- Response:
  - `rsp_valid` ← one-hot of last cycle's grant. Writes also receive a `rsp_valid` ack.
  - `rsp_rdata` = `ram_out` when `rsp_is_read`, else 0.
  - `rsp_rdata` = 0 when no `rsp_valid`.
- Requesters must hold `req_*` stable until accepted. The arbiter keeps no request buffering.

## Timing
- Reset values: `rr_ptr`=0, `lock_active`=0, `rsp_valid`=0, `rsp_rdata`=0. RAM outputs are 0 while `rst` (no grant during reset).
- Accept latency is 0 cycles: `req_ready` is combinational from `req_valid` and state.
- Response latency is exactly 1 cycle after acceptance.
- Throughput is 1 access per cycle and back-to-back grants are allowed, including to the same requester under lock.
- Write then read of the same address by consecutive grants: the read returns the new data (RAM write completes at the edge).
- Reset asserted mid-lock or with a response pending: lock is cleared, the pending `rsp_valid` is dropped, and `rr_ptr` returns to 0.
- All requesters valid, no locks: strict rotation 0,1,2,3,0…

## Structure
- Shared package `rv_mem_pkg`: `DATA_WIDTH` default, `NUM_THREADS` default, and a width function for the pointer (clog2).
- Sub-module `rv_rr_picker`: combinational round-robin picker. Inputs `req` vector and `ptr`; outputs one-hot `grant` and its encoded index. It is reusable for the instruction-fetch port.
- Top instantiates the picker, the lock mux and the response registers. Expected size is about 150–250 lines.

## Test plan
- Single request: reset, then requester 2 writes 0xC to addr 0x4. Required: `req_ready`=0100 the same cycle, `ram_we`=1 and `ram_addr`=0x4, next cycle `rsp_valid`=0100 and `rsp_rdata`=0. Then requester 2 reads 0x4: the next cycle returns 0xC.
- Rotation: all four requesters hold reads of addrs 0x10–0x1C. Required: grants 0,1,2,3,0 on consecutive cycles, each response carrying the matching addr's data one cycle later.
- Lock: requester 1 asserts lock for 3 cycles while 0 and 3 are valid. Required: grants 1,1,1, then 3 (pointer at 2), then 0.
- Lock release: requester 1 locked, then drops `req_valid` with requester 0 valid. Required: the next grant goes to 0 and `lock_active`=0.
- Reset mid-operation: assert `rst` the cycle after a read grant. Required: `rsp_valid`=0, the next grant follows pointer 0, and the RAM outputs are 0 during reset.
